// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO drain checker: state encoding and stall LFSR constants.
package fifo_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    StIdle = ST_IDLE,
    StRun  = ST_RUN,
    StDone = ST_DONE
  } state_e;

  // Galois form of x^8+x^6+x^5+x^4+1, shifting right
  localparam logic [7:0] LFSR_TAPS          = 8'hB8;
  localparam logic [7:0] STALL_SEED_DEFAULT = 8'hA5;

  function automatic logic [7:0] lfsr_step(input logic [7:0] s);
    return {1'b0, s[7:1]} ^ (s[0] ? LFSR_TAPS : 8'h00);
  endfunction

endpackage

// File: rtl/fifo_drain_lfsr.sv
// 8-bit Galois LFSR used to generate pseudo-random read backpressure.
module fifo_drain_lfsr
  import fifo_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       adv,
  input  logic [7:0] seed,
  output logic [7:0] lfsr
);

  logic [7:0] r_lfsr;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_lfsr <= seed;
    end else if (adv) begin
      r_lfsr <= lfsr_step(r_lfsr);
    end
  end

  assign lfsr = r_lfsr;

endmodule

// File: rtl/fifo_drain_checker.sv
// Read-side FIFO consumer that checks an incrementing data sequence and counts pops/errors.
// Optional random read stall is enabled by defining FIFO_DRAIN_STALL_EN.
module fifo_drain_checker
  import fifo_pkg::*;
#(
  parameter int unsigned N          = 4,
  parameter int unsigned CNT_W      = 32,
  parameter logic [7:0]  STALL_SEED = STALL_SEED_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [N-1:0]     exp_init,
  input  logic [CNT_W-1:0] drain_len,
  input  logic             empty,
  input  logic [N-1:0]     rdata,
  output logic             re,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [CNT_W-1:0] pop_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic [N-1:0]     first_bad,
  output logic [N-1:0]     first_exp
);

  state_e           r_state;
  logic [N-1:0]     r_expected;
  logic [CNT_W-1:0] r_len;
  logic [CNT_W-1:0] r_pop_cnt;
  logic [CNT_W-1:0] r_err_cnt;
  logic             r_busy;
  logic             r_done;
  logic             r_err;
  logic [N-1:0]     r_first_bad;
  logic [N-1:0]     r_first_exp;

  logic             w_stall;
  logic             w_pop;
  logic             w_mismatch;
  logic             w_last;
  logic [CNT_W-1:0] w_pop_cnt_inc;
  logic [CNT_W-1:0] w_err_cnt_inc;

`ifdef FIFO_DRAIN_STALL_EN
  logic [7:0] w_lfsr;

  fifo_drain_lfsr u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .adv  (r_state == StRun),
    .seed (STALL_SEED),
    .lfsr (w_lfsr)
  );

  assign w_stall = (w_lfsr[1:0] == 2'b00);
`else
  assign w_stall = 1'b0;
`endif

  assign re    = (r_state == StRun) && !empty && !w_stall && !rst;
  assign w_pop = re;

  assign w_mismatch    = (rdata != r_expected);
  assign w_pop_cnt_inc = r_pop_cnt + CNT_W'(1);
  assign w_err_cnt_inc = (&r_err_cnt) ? r_err_cnt : r_err_cnt + CNT_W'(1);
  // drain_len of zero means the run never terminates on its own
  assign w_last        = (r_len != '0) && (w_pop_cnt_inc == r_len);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= StIdle;
      r_expected  <= '0;
      r_len       <= '0;
      r_pop_cnt   <= '0;
      r_err_cnt   <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_first_bad <= '0;
      r_first_exp <= '0;
    end else begin
      unique case (r_state)
        StIdle, StDone: begin
          if (start) begin
            r_state     <= StRun;
            r_expected  <= exp_init;
            r_len       <= drain_len;
            r_pop_cnt   <= '0;
            r_err_cnt   <= '0;
            r_busy      <= 1'b1;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_first_bad <= '0;
            r_first_exp <= '0;
          end
        end
        StRun: begin
          if (w_pop) begin
            r_pop_cnt  <= w_pop_cnt_inc;
            // Resync on the observed value so a single dropped entry is one error
            r_expected <= rdata + N'(1);
            if (w_mismatch) begin
              r_err_cnt <= w_err_cnt_inc;
              r_err     <= 1'b1;
              if (!r_err) begin
                r_first_bad <= rdata;
                r_first_exp <= r_expected;
              end
            end
            if (w_last) begin
              r_state <= StDone;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end
          end
        end
        default: begin
          r_state <= StIdle;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign err       = r_err;
  assign pop_cnt   = r_pop_cnt;
  assign err_cnt   = r_err_cnt;
  assign first_bad = r_first_bad;
  assign first_exp = r_first_exp;

endmodule
